// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
//   Shared definitions for the bitwise logic unit and other datapath users.
//   op_e     : 3-bit operation select
//   logic_op : single-bit evaluation of an op_e on (a, b); callers apply it
//              per bit to build wider results.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_NAND  = 3'b001,
    OP_OR    = 3'b010,
    OP_NOR   = 3'b011,
    OP_XOR   = 3'b100,
    OP_XNOR  = 3'b101,
    OP_PASSA = 3'b110,
    OP_NOTA  = 3'b111
  } op_e;

  // b is a don't-care for OP_PASSA / OP_NOTA.
  function automatic logic logic_op(input logic a, input logic b, input op_e op);
    logic r;
    case (op)
      OP_AND:   r = a & b;
      OP_NAND:  r = ~(a & b);
      OP_OR:    r = a | b;
      OP_NOR:   r = ~(a | b);
      OP_XOR:   r = a ^ b;
      OP_XNOR:  r = ~(a ^ b);
      OP_PASSA: r = a;
      default:  r = ~a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/logic_unit_stage.sv
// logic_unit_stage
//   One valid/data/mode register of the result pipeline.
//   clk, rst     : clock, synchronous active-low reset
//   up_valid/up_data/up_mode : occupant offered by the previous stage
//   down_adv     : next stage can take this stage's occupant this cycle
//   adv          : this stage loads this cycle (empty, or occupant leaving)
//   valid/data/mode : registered occupant
module logic_unit_stage
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic [2:0]       up_mode,
  input  logic             down_adv,
  output logic             adv,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic [2:0]       mode
);

  // An empty stage always loads, which is what collapses bubbles
  // while later stages stall.
  assign adv = !valid || down_adv;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      mode  <= '0;
    end else if (adv) begin
      valid <= up_valid;
      // Payload only loads with a real occupant, so X never walks in.
      if (up_valid) begin
        data <= up_data;
        mode <= up_mode;
      end
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
//   WIDTH-bit bitwise logic unit followed by a STAGES-deep valid/ready
//   pipeline with bubble collapse, plus a delivered-result counter.
//   clk, rst                 : clock, synchronous active-low reset
//   in_valid/in_ready        : operand handshake
//   in_a, in_b, in_mode      : operands and op select (op_e encoding)
//   out_valid/out_ready      : result handshake
//   out_data, out_mode       : result and the mode it was computed with
//   res_cnt                  : delivered results, wraps modulo 2^CNT_W
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_mode,
  output logic [CNT_W-1:0] res_cnt
);

  // Index 0 is the input side; index s+1 is the output of stage s.
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][WIDTH-1:0] data_pipe;
  logic [STAGES:0][2:0]       mode_pipe;
  // adv[s] = stage s loads; adv[STAGES] is the downstream ready.
  logic [STAGES:0]            adv;
  logic [WIDTH-1:0]           op_res;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign op_res[i] = logic_op(in_a[i], in_b[i], op_e'(in_mode));
  end

  assign vld_pipe[0]  = in_valid;
  assign data_pipe[0] = op_res;
  assign mode_pipe[0] = in_mode;
  assign adv[STAGES]  = out_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic_unit_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (vld_pipe[s]),
      .up_data  (data_pipe[s]),
      .up_mode  (mode_pipe[s]),
      .down_adv (adv[s+1]),
      .adv      (adv[s]),
      .valid    (vld_pipe[s+1]),
      .data     (data_pipe[s+1]),
      .mode     (mode_pipe[s+1])
    );
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_pipe[STAGES];
  assign out_data  = data_pipe[STAGES];
  assign out_mode  = mode_pipe[STAGES];

  always_ff @(posedge clk) begin
    if (!rst)                        res_cnt <= '0;
    else if (out_valid && out_ready) res_cnt <= res_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;
  localparam int W  = 8;
  localparam int S  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [2:0]    in_mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [2:0]    out_mode;
  logic [CW-1:0] res_cnt;

  logic_unit_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mode(out_mode),
    .res_cnt(res_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] d; logic [2:0] m; } exp_t;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  logic [W-1:0] delivered[$];
  int exp_cnt = 0;
  int n_deliv = 0;
  int cyc = 0;
  bit rand_rdy = 0;
  bit prev_stall = 0;
  logic [W-1:0] prev_d;
  logic [2:0]   prev_m;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the eight modes written straight from their definitions.
  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [2:0] m);
    case (m)
      3'd0: return a & b;
      3'd1: return ~(a & b);
      3'd2: return a | b;
      3'd3: return ~(a | b);
      3'd4: return a ^ b;
      3'd5: return ~(a ^ b);
      3'd6: return a;
      default: return ~a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor / scoreboard: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      sb.delete();
      exp_cnt = 0;
      prev_stall = 0;
    end else begin
      chk("res_cnt", 32'(res_cnt), 32'(exp_cnt));
      chk("in_ready", 32'(in_ready), 32'((sb.size() < S) || out_ready));
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'(1));
        chk("hold_data", 32'(out_data), 32'(prev_d));
        chk("hold_mode", 32'(out_mode), 32'(prev_m));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ghost_output: got data %0h with nothing outstanding", out_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_mode", 32'(out_mode), 32'(e.m));
        end
        delivered.push_back(out_data);
        n_deliv++;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_m = out_mode;
      if (in_valid && in_ready) begin
        e.d = ref_op(in_a, in_b, in_mode);
        e.m = in_mode;
        sb.push_back(e);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input string name);
    bit done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (in_ready) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: accept timeout, got in_ready=0 expected 1", name);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] m,
                      input string name);
    in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
    wait_acc(name);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
  endtask

  logic [W-1:0] tbl [8];
  int c0, d0, base;

  initial begin
    tbl = '{8'h81, 8'h7E, 8'hE7, 8'h18, 8'h66, 8'h99, 8'hC3, 8'h3C};

    // 1: reset held with in_valid high
    rst = 1'b0; in_valid = 1'b1; in_a = 8'h5A; in_b = 8'h0F; in_mode = 3'd2;
    tick(1);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_res_cnt", 32'(res_cnt), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    tick(2);
    rst = 1'b1; in_valid = 1'b0;
    tick(6);
    chk("rst_quiet", 32'(out_valid), 32'(0));

    // 2: all modes back-to-back
    out_ready = 1'b1;
    delivered.delete();
    for (int m = 0; m < 8; m++) send(8'hC3, 8'hA5, 3'(m), "modes");
    tick(4);
    chk("modes_count", 32'(delivered.size()), 32'(8));
    for (int i = 0; i < 8 && i < delivered.size(); i++) chk("modes_table", 32'(delivered[i]), 32'(tbl[i]));
    chk("modes_res_cnt", 32'(res_cnt), 32'(8));

    // 3: backpressure
    out_ready = 1'b0;
    base = delivered.size();
    send(8'hF0, 8'h3C, 3'd2, "bp1");
    send(8'h0F, 8'h55, 3'd4, "bp2");
    in_a = 8'hAA; in_b = 8'h12; in_mode = 3'd7; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_valid", 32'(out_valid), 32'(1));
      chk("bp_data", 32'(out_data), 32'(8'hFC));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_acc("bp3");
    tick(4);
    chk("bp_count", 32'(delivered.size() - base), 32'(3));
    if (delivered.size() - base == 3) begin
      chk("bp_order0", 32'(delivered[base]), 32'(8'hFC));
      chk("bp_order1", 32'(delivered[base+1]), 32'(8'h5A));
      chk("bp_order2", 32'(delivered[base+2]), 32'(8'h55));
    end

    // 4: full throughput
    out_ready = 1'b0;
    send(W'($urandom), W'($urandom), 3'($urandom), "fill");
    send(W'($urandom), W'($urandom), 3'($urandom), "fill");
    out_ready = 1'b1;
    c0 = cyc; d0 = n_deliv;
    for (int i = 0; i < 10; i++) send(W'($urandom), W'($urandom), 3'($urandom), "burst");
    chk("burst_cycles", 32'(cyc - c0), 32'(10));
    chk("burst_deliv", 32'(n_deliv - d0), 32'(10));
    tick(4);

    // 5: mid-flight reset flushes
    out_ready = 1'b0;
    send(8'h11, 8'h22, 3'd2, "flush");
    send(8'h33, 8'h44, 3'd4, "flush");
    do_reset();
    @(negedge clk);
    chk("flush_valid", 32'(out_valid), 32'(0));
    chk("flush_res_cnt", 32'(res_cnt), 32'(0));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    tick(6);
    chk("flush_quiet", 32'(out_valid), 32'(0));

    // 6: counter wrap (CNT_W=4)
    do_reset();
    for (int i = 0; i < 17; i++) send(W'($urandom), W'($urandom), 3'($urandom), "wrap");
    tick(4);
    chk("wrap_res_cnt", 32'(res_cnt), 32'(1));

    // Random traffic with random downstream stalls
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
      send(W'($urandom), W'($urandom), 3'($urandom), "random");
    end
    rand_rdy = 0;
    tick(1);
    out_ready = 1'b1;
    tick(8);
    chk("drain_empty", 32'(sb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
